// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, writeback source encodings and the register
// one-hot decode used by the writeback arbiter and its scoreboard.
package regfile_pkg;

    localparam int AW       = 4;
    localparam int DW       = 32;
    localparam int NUM_REGS = 16;

    // Source encodings; also the values held by the round-robin pointer.
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

    // One-hot decode of a register address into a NUM_REGS-wide vector.
    function automatic logic [NUM_REGS-1:0] onehot_dec(input logic [AW-1:0] addr);
        logic [NUM_REGS-1:0] vec;
        vec       = '0;
        vec[addr] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write flags. The issue stage sets
// a flag when it dispatches a producer; the writeback path clears it when the
// result is written. A set and a clear of the same register in one cycle
// leave the flag set, because the set belongs to a newer producer. Register 0
// never holds a pending write, so its flag is tied low.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [AW-1:0]       set_addr,
    input  logic                clr_en,
    input  logic [AW-1:0]       clr_addr,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] busy_q;

    // Decode set and clear requests into per-register strobes.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) begin
            set_vec = onehot_dec(set_addr);
        end
        if (clr_en) begin
            clr_vec = onehot_dec(clr_addr);
        end
    end

    // Register 0 is hardwired zero and can never be pending.
    assign busy_d[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_bit
            // Set has priority over clear on the same register.
            assign busy_d[gi] = set_vec[gi] | (busy_q[gi] & ~clr_vec[gi]);
        end
    endgenerate

    // Scoreboard state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between the ALU
// (src 0) and LSU (src 1) writeback sources using valid/ready handshakes.
// The winning request is registered onto we/writeAddr/writeData one cycle
// after acceptance, and the per-register busy scoreboard is cleared on the
// same edge. Widths come from regfile_pkg.
//
// Build option WB_RR_ARB_EN: when defined, contention is resolved
// round-robin using a 1-bit pointer to the last granted source; when
// undefined, the LSU always wins over the ALU and no pointer exists.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [AW-1:0]       alu_addr,
    input  logic [DW-1:0]       alu_data,
    input  logic                lsu_valid,
    output logic                lsu_ready,
    input  logic [AW-1:0]       lsu_addr,
    input  logic [DW-1:0]       lsu_data,
    input  logic                wb_stall,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    output logic [NUM_REGS-1:0] busy,
    output logic                we,
    output logic [AW-1:0]       writeAddr,
    output logic [DW-1:0]       writeData
);

    logic          alu_win;
    logic          lsu_win;
    logic          accept;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_data;

    logic          we_d;
    logic          we_q;
    logic [AW-1:0] write_addr_d;
    logic [AW-1:0] write_addr_q;
    logic [DW-1:0] write_data_d;
    logic [DW-1:0] write_data_q;

`ifdef WB_RR_ARB_EN
    logic rr_ptr_d;
    logic rr_ptr_q;

    // Winner select: on contention grant the source that did not win last.
    always_comb begin
        alu_win = 1'b0;
        lsu_win = 1'b0;
        if (alu_valid && lsu_valid) begin
            if (rr_ptr_q == SRC_ALU) begin
                lsu_win = 1'b1;
            end else begin
                alu_win = 1'b1;
            end
        end else begin
            alu_win = alu_valid;
            lsu_win = lsu_valid;
        end
    end

    // Pointer follows the source of each accepted transfer, including r0 writes.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (lsu_ready) begin
            rr_ptr_d = SRC_LSU;
        end else if (alu_ready) begin
            rr_ptr_d = SRC_ALU;
        end
    end

    // Round-robin pointer register; starts at the ALU so the LSU wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= SRC_ALU;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Winner select: fixed priority, LSU over ALU.
    always_comb begin
        lsu_win = lsu_valid;
        alu_win = alu_valid && !lsu_valid;
    end
`endif

    // Readies depend only on valid, stall and the winner, never on ready.
    assign alu_ready = alu_valid && !wb_stall && alu_win;
    assign lsu_ready = lsu_valid && !wb_stall && lsu_win;

    // Accepted request mux and next-state of the write port registers.
    // A transfer to r0 is consumed but never raises we; the address and data
    // registers only move on a real write so they hold across idle cycles.
    always_comb begin
        accept       = alu_ready || lsu_ready;
        acc_addr     = lsu_ready ? lsu_addr : alu_addr;
        acc_data     = lsu_ready ? lsu_data : alu_data;
        we_d         = accept && (acc_addr != '0);
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        if (we_d) begin
            write_addr_d = acc_addr;
            write_data_d = acc_data;
        end
    end

    // Registered write port towards the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q         <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            we_q         <= we_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    assign we        = we_q;
    assign writeAddr = write_addr_q;
    assign writeData = write_data_q;

    // The clear strobe is the same condition that raises we next edge.
    regfile_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (sb_set),
        .set_addr (sb_addr),
        .clr_en   (we_d),
        .clr_addr (acc_addr),
        .busy     (busy)
    );

endmodule
